pram_arbiter: RTL
=================

PRAM_ARBITER -- requirements
Module: pram_arbiter

Interface
REQ-001 clk  in  1  system clock; all state changes on its rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 if_req, if_addr  in  1, 16  instruction fetch request and byte address; if_addr[1:0] ignored (word fetch).
REQ-004 if_gnt, if_rvalid, if_rdata  out  1, 1, 32  fetch issued this cycle; fetch data valid; fetch data.
REQ-005 ls_req, ls_wen, ls_addr, ls_size, ls_wdata  in  1, 1, 16, 2, 32  internal load/store request from the load/store controller; 1 = store; byte address; 00 byte, 01 half, 10 word (11 treated as word); unaligned store data in bits [7:0]/[15:0]/[31:0].
REQ-006 pram_ld_done, pram_st_done, ls_rdata  out  1, 1, 32  load complete; store complete; raw 32-bit read word, with lane selection done downstream.
REQ-007 pram_en, pram_we, pram_be, pram_addr, pram_wdata  out  1, 1, 4, 16, 32  single-port PRAM strobe, write, byte enables, word-aligned address (bits [1:0] = 00), lane-replicated write data.
REQ-008 pram_rdata  in  32  PRAM read data, valid the cycle after pram_en with pram_we=0.
REQ-009 ls_misalign  out  1  misaligned access reject pulse; present only with PRAM_ARB_MISALIGN_EN.

Function
REQ-010 FSM states: IDLE, FETCH, LOAD, STORE; encoding from the shared package.
REQ-011 In IDLE, ls_req has priority over if_req; the winner is issued combinationally in the same cycle: pram_en=1, pram_addr={addr[15:2],2'b00}.
REQ-012 Transitions from IDLE:
- ls_req & ls_wen -> STORE
- ls_req & !ls_wen -> LOAD
- else if_req -> FETCH
- else stay in IDLE.
REQ-013 FETCH, LOAD and STORE each last exactly one cycle, then return to IDLE; sustained throughput is one access per 2 cycles.
REQ-014 FETCH state: if_rvalid=1, if_rdata=pram_rdata.
REQ-015 LOAD state: pram_ld_done=1, ls_rdata=pram_rdata.
REQ-016 STORE state: pram_st_done=1.
REQ-017 Each done or valid output is a one-cycle pulse, asserted exactly 1 cycle after issue.
REQ-018 if_gnt=1 only in the IDLE cycle that issues a fetch.
REQ-019 Store byte enables:
- size 00: be = 4'b0001 << addr[1:0]
- size 01: be = addr[1] ? 1100 : 0011
- size 10/11: be = 1111
REQ-020 Store write data: size 00 -> {4{wdata[7:0]}}; size 01 -> {2{wdata[15:0]}}; word passes through unchanged.
REQ-021 Loads and fetches drive pram_be=1111 and pram_we=0.
REQ-022 Request operands are registered at issue; a requester dropping req or changing operands mid-operation does not abort the access, and its done/valid pulse still occurs.
REQ-023 When neither request is active, or in a non-IDLE state: pram_en=0, pram_we=0, pram_be=0, pram_addr=0, pram_wdata=0.
REQ-024 When if_req and ls_req are asserted together, the LS access is issued first and the fetch is issued in the IDLE cycle following LS completion, if if_req is still high.
REQ-025 if_rdata and ls_rdata read 0 outside their valid cycles.

Reset
REQ-026 When rst is sampled high, the next state is IDLE and all registered operands are cleared.
REQ-027 While rst is high, every output is 0.
REQ-028 Reset during FETCH, LOAD or STORE suppresses that state's done/valid pulse.
REQ-029 A store already strobed to the PRAM is not rolled back by reset.

Configuration
REQ-030 Macro PRAM_ARB_MISALIGN_EN.
REQ-031 With PRAM_ARB_MISALIGN_EN defined, an LS request with (size 01 & addr[0]) or (size 1x & addr[1:0]!=0) is misaligned:
- it is not issued to the PRAM (pram_en=0)
- the FSM still enters LOAD/STORE
- that state pulses ls_misalign=1 together with the normal done pulse
- ls_rdata=0 and no write occurs.
REQ-032 Without PRAM_ARB_MISALIGN_EN, the ls_misalign port does not exist and misaligned requests are issued with the REQ-019 enables.

Structure
REQ-033 Package pram_arb_pkg holds the FSM state encoding and the access-size constants SZ_BYTE=00, SZ_HALF=01, SZ_WORD=10.
REQ-034 The byte-enable and lane-replication logic is the sub-module pram_be_gen (inputs size, addr[1:0], wdata; outputs be, wdata_rep).

Verification
REQ-035 Fetch only: if_req=1, if_addr=16'h0104 -> issue cycle: if_gnt=1, pram_addr=0104; next cycle: if_rvalid=1, if_rdata=pram_rdata.
REQ-036 Simultaneous requests: if_req=1, ls_req=1, ls_wen=0, ls_addr=0200 -> LS issued first, pram_ld_done pulses at cycle+1, fetch if_gnt at cycle+2, if_rvalid at cycle+3.
REQ-037 Byte store: ls_addr=0x0203, size 00, wdata=0xAB -> pram_be=1000, pram_wdata=ABABABAB, pram_st_done at cycle+1.
REQ-038 Half store: ls_addr=0x0202, size 01, wdata=0x1234 -> pram_be=1100, pram_wdata=12341234.
REQ-039 Reset mid-operation: rst asserted in the LOAD state -> no pram_ld_done pulse, state IDLE and all outputs 0 on the following cycle.
REQ-040 With PRAM_ARB_MISALIGN_EN: word load at ls_addr=0x0201 -> pram_en=0; next cycle ls_misalign=1, pram_ld_done=1, ls_rdata=0.

Source files
------------

// File: rtl/pram_arb_pkg.sv
// Shared definitions for the PRAM arbiter: FSM encoding, access sizes and the
// alignment rule used when PRAM_ARB_MISALIGN_EN is defined.
package pram_arb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_LOAD  = 2'd2;
  localparam logic [1:0] ST_STORE = 2'd3;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Size 11 behaves as a word, so any size with bit 1 set needs word alignment.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    if (size == SZ_HALF)
      return addr_lo[0];
    else if (size[1])
      return addr_lo != 2'b00;
    else
      return 1'b0;
  endfunction

endpackage

// File: rtl/pram_be_gen.sv
// Store byte-enable generation and write-data lane replication for the
// 32-bit PRAM port.
module pram_be_gen
  import pram_arb_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep
);

  always_comb begin
    be        = 4'b1111;
    wdata_rep = wdata;
    case (size)
      SZ_BYTE: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
      end
      default: begin
        be        = 4'b1111;
        wdata_rep = wdata;
      end
    endcase
  end

endmodule

// File: rtl/pram_arbiter.sv
// Single-port PRAM arbiter between instruction fetch and load/store; LS wins.
// Optional misaligned-access rejection is built when PRAM_ARB_MISALIGN_EN is defined.
//
// Handshake: a request is taken in the IDLE cycle where it wins arbitration
// (if_gnt marks a taken fetch); exactly one cycle later the matching
// if_rvalid / pram_ld_done / pram_st_done pulses for one cycle. Requests are
// not held off otherwise; a requester simply keeps req high until it is served.
module pram_arbiter
  import pram_arb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        ls_req,
  input  logic        ls_wen,
  input  logic [15:0] ls_addr,
  input  logic [1:0]  ls_size,
  input  logic [31:0] ls_wdata,
  output logic        pram_ld_done,
  output logic        pram_st_done,
  output logic [31:0] ls_rdata,
  output logic        pram_en,
  output logic        pram_we,
  output logic [3:0]  pram_be,
  output logic [15:0] pram_addr,
  output logic [31:0] pram_wdata,
  input  logic [31:0] pram_rdata,
  output logic [1:0]  dbg_state
`ifdef PRAM_ARB_MISALIGN_EN
  ,
  output logic        ls_misalign
`endif
);

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic        idle;
  logic        issue_ls;
  logic        issue_if;
  logic        ls_mis_now;
  logic        op_mis;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;

  pram_be_gen u_be_gen (
    .size      (ls_size),
    .addr_lo   (ls_addr[1:0]),
    .wdata     (ls_wdata),
    .be        (st_be),
    .wdata_rep (st_wdata)
  );

`ifdef PRAM_ARB_MISALIGN_EN
  assign ls_mis_now = is_misaligned(ls_size, ls_addr[1:0]);
`else
  assign ls_mis_now = 1'b0;
`endif

  // Gating with rst keeps every output at zero while reset is held.
  assign idle     = (state == ST_IDLE) && !rst;
  assign issue_ls = idle && ls_req;
  assign issue_if = idle && !ls_req && if_req;

  always_comb begin
    pram_en    = 1'b0;
    pram_we    = 1'b0;
    pram_be    = 4'b0000;
    pram_addr  = 16'h0000;
    pram_wdata = 32'h0000_0000;
    if (issue_ls && !ls_mis_now) begin
      pram_en    = 1'b1;
      pram_we    = ls_wen;
      pram_be    = ls_wen ? st_be : 4'b1111;
      pram_addr  = {ls_addr[15:2], 2'b00};
      pram_wdata = ls_wen ? st_wdata : 32'h0000_0000;
    end else if (issue_if) begin
      pram_en   = 1'b1;
      pram_be   = 4'b1111;
      pram_addr = {if_addr[15:2], 2'b00};
    end
  end

  always_comb begin
    state_nxt = ST_IDLE;
    if (state == ST_IDLE) begin
      if (ls_req)
        state_nxt = ls_wen ? ST_STORE : ST_LOAD;
      else if (if_req)
        state_nxt = ST_FETCH;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      op_mis <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && ls_req)
        op_mis <= ls_mis_now;
    end
  end

  assign if_gnt       = issue_if;
  assign if_rvalid    = !rst && (state == ST_FETCH);
  assign if_rdata     = if_rvalid ? pram_rdata : 32'h0000_0000;
  assign pram_ld_done = !rst && (state == ST_LOAD);
  assign pram_st_done = !rst && (state == ST_STORE);
  assign ls_rdata     = (pram_ld_done && !op_mis) ? pram_rdata : 32'h0000_0000;
  assign dbg_state    = rst ? ST_IDLE : state;

`ifdef PRAM_ARB_MISALIGN_EN
  assign ls_misalign = (pram_ld_done || pram_st_done) && op_mis;
`endif

endmodule
